// File: rtl/updown_counter_snap_pkg.sv
//------------------------------------------------------------------------------
// Module   : updown_counter_snap_pkg
// Brief    : Shared status-bit indices, widths and command encoding for the
//            trigger-driven up/down counter with coherent snapshot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package updown_counter_snap_pkg;

    localparam int ST_OVF   = 0;
    localparam int ST_UNF   = 1;
    localparam int ST_COLL  = 2;
    localparam int ST_THR   = 3;
    localparam int ST_SNAP  = 4;
    localparam int STATUS_W = 8;
    localparam int HALF_W   = 16;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_CLR  = 3'd1,
        CMD_LOAD = 3'd2,
        CMD_UP   = 3'd3,
        CMD_DOWN = 3'd4,
        CMD_HOLD = 3'd5
    } cmd_e;

endpackage

`default_nettype wire

// File: rtl/updown_counter_snap_capture.sv
//------------------------------------------------------------------------------
// Module   : updown_counter_snap_capture
// Brief    : Snapshot register split into two 16-bit halves so the host can
//            read low and high words on separate transactions without tearing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module updown_counter_snap_capture
    import updown_counter_snap_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [WIDTH-1:0]  count,
    output logic [HALF_W-1:0] snap_lo,
    output logic [HALF_W-1:0] snap_hi
);

    logic [WIDTH-1:0] r_snap;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_snap <= '0;
        end else if (capture) begin
            r_snap <= count;
        end
    end

    assign snap_lo = r_snap[HALF_W-1:0];

    generate
        if (WIDTH == 2 * HALF_W) begin : g_full_hi
            assign snap_hi = r_snap[WIDTH-1:HALF_W];
        end else begin : g_zext_hi
            assign snap_hi = {{(2 * HALF_W - WIDTH){1'b0}}, r_snap[WIDTH-1:HALF_W]};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/updown_counter_snap.sv
//------------------------------------------------------------------------------
// Module   : updown_counter_snap
// Brief    : Trigger-driven up/down counter with sticky status, wrap/threshold
//            pulses and a coherent snapshot. UPDOWN_COUNTER_SNAP_SATURATE_EN
//            selects saturating instead of modulo arithmetic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module updown_counter_snap
    import updown_counter_snap_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                up,
    input  logic                down,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic [WIDTH-1:0]    threshold,
    input  logic                capture,
    input  logic                status_clr,
    output logic [WIDTH-1:0]    count,
    output logic [HALF_W-1:0]   snap_lo,
    output logic [HALF_W-1:0]   snap_hi,
    output logic                wrap_pulse,
    output logic                thresh_pulse,
    output logic [STATUS_W-1:0] status
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef UPDOWN_COUNTER_SNAP_SATURATE_EN
    localparam bit c_SATURATE = 1'b1;
`else
    localparam bit c_SATURATE = 1'b0;
`endif

    cmd_e             w_cmd;
    logic [WIDTH-1:0] w_count_next;
    logic             w_ovf;
    logic             w_unf;
    logic             w_wrap;
    logic             w_eq_next;
    logic             w_thr_rise;
    logic [4:0]       w_set;

    logic [WIDTH-1:0] r_count;
    logic [4:0]       r_status;
    logic             r_eq;
    logic             r_wrap;
    logic             r_thr;

    always_comb begin
        w_cmd = CMD_NONE;
        if (clr)              w_cmd = CMD_CLR;
        else if (load)        w_cmd = CMD_LOAD;
        else if (up && down)  w_cmd = CMD_HOLD;
        else if (up)          w_cmd = CMD_UP;
        else if (down)        w_cmd = CMD_DOWN;
    end

    always_comb begin
        w_count_next = r_count;
        w_ovf        = 1'b0;
        w_unf        = 1'b0;
        w_wrap       = 1'b0;
        case (w_cmd)
            CMD_CLR:  w_count_next = RESET_VAL;
            CMD_LOAD: w_count_next = load_val;
            CMD_UP: begin
                if (r_count == c_ALL_ONES) begin
                    w_ovf        = 1'b1;
                    w_wrap       = !c_SATURATE;
                    w_count_next = c_SATURATE ? c_ALL_ONES : '0;
                end else begin
                    w_count_next = r_count + c_ONE;
                end
            end
            CMD_DOWN: begin
                if (r_count == '0) begin
                    w_unf        = 1'b1;
                    w_wrap       = !c_SATURATE;
                    w_count_next = c_SATURATE ? '0 : c_ALL_ONES;
                end else begin
                    w_count_next = r_count - c_ONE;
                end
            end
            default: ;
        endcase
    end

    // Equality is judged on the value count will show, so the pulse lines up with it.
    assign w_eq_next  = (w_count_next == threshold);
    assign w_thr_rise = w_eq_next && !r_eq;

    always_comb begin
        w_set          = '0;
        w_set[ST_OVF]  = w_ovf;
        w_set[ST_UNF]  = w_unf;
        w_set[ST_COLL] = (w_cmd == CMD_HOLD);
        w_set[ST_THR]  = w_thr_rise;
        w_set[ST_SNAP] = capture;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_count  <= RESET_VAL;
            r_status <= '0;
            r_eq     <= (RESET_VAL == threshold);
            r_wrap   <= 1'b0;
            r_thr    <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_status <= (status_clr ? 5'b0 : r_status) | w_set;
            r_eq     <= w_eq_next;
            r_wrap   <= w_wrap;
            r_thr    <= w_thr_rise;
        end
    end

    updown_counter_snap_capture #(
        .WIDTH (WIDTH)
    ) u_capture (
        .sys_clk (sys_clk),
        .reset   (reset),
        .capture (capture),
        .count   (r_count),
        .snap_lo (snap_lo),
        .snap_hi (snap_hi)
    );

    assign count        = r_count;
    assign wrap_pulse   = r_wrap;
    assign thresh_pulse = r_thr;
    assign status       = {{(STATUS_W-5){1'b0}}, r_status};

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_snap.sv
//------------------------------------------------------------------------------
// Module   : tb_updown_counter_snap
// Brief    : Scoreboard bench with a behavioural reference model for the
//            up/down counter with snapshot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_updown_counter_snap;

    localparam int          W    = 32;
    localparam logic [31:0] RV   = 32'h0;
    localparam longint      MAXV = 64'hFFFF_FFFF;
`ifdef UPDOWN_COUNTER_SNAP_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1, clr = 1'b0, up = 1'b0, down = 1'b0, load = 1'b0;
    logic        capture = 1'b0, status_clr = 1'b0;
    logic [31:0] load_val = '0, threshold = '0;
    logic [31:0] count;
    logic [15:0] snap_lo, snap_hi;
    logic        wrap_pulse, thresh_pulse;
    logic [7:0]  status;

    always #5 sys_clk = ~sys_clk;

    updown_counter_snap #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .sys_clk(sys_clk), .reset(reset), .clr(clr), .up(up), .down(down),
        .load(load), .load_val(load_val), .threshold(threshold),
        .capture(capture), .status_clr(status_clr), .count(count),
        .snap_lo(snap_lo), .snap_hi(snap_hi), .wrap_pulse(wrap_pulse),
        .thresh_pulse(thresh_pulse), .status(status)
    );

    typedef struct {
        logic [31:0] count;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        wrap;
        logic        thp;
        logic [7:0]  status;
    } exp_t;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    longint m_count   = 0;
    longint m_snap    = 0;
    bit [7:0] m_status = '0;
    bit     m_prev_eq = 1'b0;
    longint cur_thr   = 64'h1234_5678;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the reference model decides what the outputs must show next.
    task automatic step(input bit r, input bit c, input bit l, input bit u, input bit d,
                        input bit cap, input bit sc, input longint lv);
        longint   old;
        bit       wrap;
        bit       thp;
        bit [4:0] set;
        exp_t     e;
        @(negedge sys_clk);
        reset = r; clr = c; load = l; up = u; down = d;
        capture = cap; status_clr = sc;
        load_val = lv[31:0]; threshold = cur_thr[31:0];
        wrap = 1'b0; thp = 1'b0; set = '0;
        if (r) begin
            m_count = longint'(RV); m_snap = 0; m_status = '0;
            m_prev_eq = (longint'(RV) == cur_thr);
        end else begin
            old = m_count;
            if (cap) begin m_snap = old; set[4] = 1'b1; end
            if (c) m_count = longint'(RV);
            else if (l) m_count = lv & MAXV;
            else if (u && d) set[2] = 1'b1;
            else if (u) begin
                if (old == MAXV) begin
                    set[0] = 1'b1;
                    if (!SAT) begin m_count = 0; wrap = 1'b1; end
                end else m_count = old + 1;
            end else if (d) begin
                if (old == 0) begin
                    set[1] = 1'b1;
                    if (!SAT) begin m_count = MAXV; wrap = 1'b1; end
                end else m_count = old - 1;
            end
            thp = (m_count == cur_thr) && !m_prev_eq;
            m_prev_eq = (m_count == cur_thr);
            if (thp) set[3] = 1'b1;
            if (sc) m_status[4:0] = '0;
            m_status[4:0] = m_status[4:0] | set;
        end
        e.count  = m_count[31:0];
        e.lo     = m_snap[15:0];
        e.hi     = m_snap[31:16];
        e.wrap   = wrap;
        e.thp    = thp;
        e.status = m_status;
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic longint pick_lv();
        case ($urandom_range(0, 6))
            0: return 0;
            1: return MAXV;
            2: return MAXV - 1;
            3: return 64'h1_FFFF;
            4: return longint'($urandom_range(0, 20));
            5: return 1;
            default: return longint'($urandom);
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count",        count,        e.count);
                chk("snap_lo",      snap_lo,      e.lo);
                chk("snap_hi",      snap_hi,      e.hi);
                chk("wrap_pulse",   wrap_pulse,   e.wrap);
                chk("thresh_pulse", thresh_pulse, e.thp);
                chk("status",       status,       e.status);
            end
        end
    end

    initial begin : stimulus
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle();

        step(0, 0, 1, 0, 0, 0, 0, 64'hFFFF_FFFE);
        repeat (2) step(0, 0, 0, 1, 0, 0, 0, 0);
        idle();

        cur_thr = 5;
        step(0, 0, 1, 0, 0, 0, 0, 4);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) idle();

        step(0, 0, 1, 0, 0, 0, 0, 10);
        step(0, 0, 0, 1, 1, 0, 0, 0);
        idle();
        step(0, 0, 1, 0, 0, 0, 0, MAXV);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        idle();

        step(0, 0, 1, 0, 0, 0, 0, 64'h1_FFFF);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        repeat (100) step(0, 0, 0, 1, 0, 0, 0, 0);

        step(0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0, 1, 0, 64'h55);
        idle();

        step(0, 0, 1, 0, 0, 0, 0, 42);
        idle();
        cur_thr = 42;
        repeat (3) idle();
        step(0, 0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bit r, c, l, u, d, cap, sc;
            if ($urandom_range(0, 9) == 0)
                cur_thr = (m_count + longint'($urandom_range(0, 3)) - 1) & MAXV;
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 39) == 0);
            l   = ($urandom_range(0, 14) == 0);
            u   = ($urandom_range(0, 1) == 0);
            d   = ($urandom_range(0, 2) == 0);
            cap = ($urandom_range(0, 7) == 0);
            sc  = ($urandom_range(0, 9) == 0);
            step(r, c, l, u, d, cap, sc, pick_lv());
        end

        repeat (3) idle();
        @(posedge sys_clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
